// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot band scheduler: FSM states and
// the signed fixed-point coordinate format (FP_INT integer bits, rest fraction).
package mandel_pkg;

  localparam int FP_WIDTH = 25;
  localparam int FP_INT   = 4;

  typedef logic signed [FP_WIDTH-1:0] fp_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FIN
  } sched_state_t;

endpackage

// File: rtl/mandel_pick_free.sv
// Lowest-index-free priority encoder: finds the first engine whose inflight
// bit is clear.
module mandel_pick_free #(
  parameter int N = 4
) (
  input  logic [N-1:0] inflight,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top so the lowest free index is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!inflight[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/mandel_band_sched.sv
// Splits a frame into horizontal bands and hands them to NUM_ENG render engines.
// Optional frame cycle counter enabled by defining MANDEL_SCHED_STATS_EN.
module mandel_band_sched #(
  parameter int CORDW     = 16,
  parameter int FP_WIDTH  = mandel_pkg::FP_WIDTH,
  parameter int FB_HEIGHT = 180,
  parameter int BAND_H    = 20,
  parameter int NUM_ENG   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [FP_WIDTH-1:0]    x_start,
  input  logic signed [FP_WIDTH-1:0]    y_start,
  input  logic signed [FP_WIDTH-1:0]    step,
  output logic [NUM_ENG-1:0]            eng_start,
  output logic signed [FP_WIDTH-1:0]    eng_x_start,
  output logic signed [FP_WIDTH-1:0]    eng_step,
  output logic [NUM_ENG*FP_WIDTH-1:0]   eng_y_start,
  output logic [NUM_ENG*CORDW-1:0]      eng_row0,
  input  logic [NUM_ENG-1:0]            eng_done,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   frame_cycles
);
  import mandel_pkg::*;

  localparam int NUM_BANDS = FB_HEIGHT / BAND_H;
  localparam int BW        = $clog2(NUM_BANDS + 1);

  sched_state_t                state, state_nxt;
  logic                        pending;
  logic [NUM_ENG-1:0]          inflight;
  logic [BW-1:0]               band;
  logic signed [FP_WIDTH-1:0]  y_acc, band_step;
  logic signed [FP_WIDTH-1:0]  y_reg [NUM_ENG];
  logic [CORDW-1:0]            row_reg [NUM_ENG];
  logic [CORDW-1:0]            row_cur;
  logic                        free_valid;
  logic [2:0]                  free_idx;
  logic                        accept, dispatch, last_band;

  mandel_pick_free #(.N(NUM_ENG)) u_pick (
    .inflight (inflight),
    .valid    (free_valid),
    .idx      (free_idx)
  );

  assign accept    = (state == IDLE) && (start || pending);
  assign dispatch  = (state == DISPATCH) && free_valid;
  assign last_band = (band == BW'(NUM_BANDS - 1));
  assign row_cur   = CORDW'(32'(band) * BAND_H);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = DISPATCH;
      DISPATCH: if (dispatch && last_band) state_nxt = DRAIN;
      DRAIN:    if (inflight == '0) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    eng_start = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (dispatch && free_idx == 3'(i)) eng_start[i] = 1'b1;
    end
  end

  // A done on an engine not in flight is masked out by the AND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      inflight    <= '0;
      band        <= '0;
      y_acc       <= '0;
      band_step   <= '0;
      eng_x_start <= '0;
      eng_step    <= '0;
      for (int i = 0; i < NUM_ENG; i++) begin
        y_reg[i]   <= '0;
        row_reg[i] <= '0;
      end
    end else begin
      if (busy && start)  pending <= 1'b1;
      else if (accept)    pending <= 1'b0;
      inflight <= (inflight & ~eng_done) | eng_start;
      if (accept) begin
        band        <= '0;
        y_acc       <= y_start;
        band_step   <= step * FP_WIDTH'(BAND_H);
        eng_x_start <= x_start;
        eng_step    <= step;
      end else if (dispatch) begin
        band  <= band + 1'b1;
        y_acc <= y_acc + band_step;
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        if (eng_start[i]) begin
          y_reg[i]   <= y_acc;
          row_reg[i] <= row_cur;
        end
      end
    end
  end

  // During the dispatch cycle the slice shows the band being handed out.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_out
    assign eng_y_start[g*FP_WIDTH +: FP_WIDTH] = eng_start[g] ? y_acc   : y_reg[g];
    assign eng_row0[g*CORDW +: CORDW]          = eng_start[g] ? row_cur : row_reg[g];
  end

`ifdef MANDEL_SCHED_STATS_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      if (accept)                            cyc_cnt <= 32'd1;
      else if (busy && cyc_cnt != '1)        cyc_cnt <= cyc_cnt + 32'd1;
      if (state == FIN) frame_cycles <= (cyc_cnt == '1) ? '1 : cyc_cnt + 32'd1;
    end
  end
`else
  assign frame_cycles = '0;
`endif

endmodule
